bcd_score_up_counter: RTL and testbench

//  Multi-digit BCD up counter that accumulates game score. It is the counting-up

---
 rtl/bcd_score_up_counter_if.sv | 24 ++
 rtl/bcd_score_up_counter.sv | 105 ++++++++++
 tb/tb_bcd_score_up_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_score_up_counter_if.sv
// Score counter request/status bundle: the requester drives clear and add
// requests, the counter returns the handshake, the BCD score and its flags.
interface bcd_score_up_counter_if #(
    parameter int DIGITS = 4
);
    logic                  clear;
    logic                  add_valid;
    logic [3:0]            add_value;
    logic                  add_ready;
    logic [4*DIGITS-1:0]   score;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output clear, add_valid, add_value,
        input  add_ready, score, busy, done, overflow
    );

    modport slave (
        input  clear, add_valid, add_value,
        output add_ready, score, busy, done, overflow
    );
endinterface

// File: rtl/bcd_score_up_counter.sv
// Multi-digit BCD score accumulator: adds 0..9 points per request and ripples
// the carry one digit per clock, saturating at all nines with a sticky overflow.
module bcd_score_up_counter #(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    bcd_score_up_counter_if.slave   bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [3:0]          v_q, v_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [3:0]          digit;
    logic [4:0]          sum;
    logic [4:0]          wrapped;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            v_q     <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            v_q     <= v_d;
            score_q <= score_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        v_d     = v_q;
        score_d = score_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        // The latched value only enters at the least significant digit.
        digit   = score_q[4*idx_q +: 4];
        sum     = {1'b0, digit} + {4'b0000, carry_q}
                + ((idx_q == '0) ? {1'b0, v_q} : 5'd0);
        wrapped = sum - 5'd10;

        if (bus.clear) begin
            state_d = IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
            score_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.add_valid) begin
                        v_d     = (bus.add_value > 4'd9) ? 4'd9 : bus.add_value;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        state_d = ADD;
                    end
                end
                ADD: begin
                    if (sum > 5'd9) begin
                        if (idx_q == IW'(DIGITS - 1)) begin
                            score_d = {DIGITS{4'h9}};
                            ovf_d   = 1'b1;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            score_d[4*idx_q +: 4] = wrapped[3:0];
                            idx_d   = idx_q + IW'(1);
                            carry_d = 1'b1;
                        end
                    end else begin
                        score_d[4*idx_q +: 4] = sum[3:0];
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.add_ready = (state_q == IDLE) && !bus.clear;
    assign bus.score     = score_q;
    assign bus.busy      = (state_q == ADD);
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bcd_score_up_counter.sv
// Directed bench for bcd_score_up_counter: hand-computed score sequences,
// carry ripple timing, saturation, clear priority and async reset.
module tb_bcd_score_up_counter;
    logic clk;
    logic resetN;
    int   n_cmp;
    int   n_bad;

    bcd_score_up_counter_if #(.DIGITS(4)) bus_if ();

    bcd_score_up_counter #(.DIGITS(4)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges from the current point until done is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cycles++;
            if (bus_if.done) break;
        end
        check("done_seen", {31'b0, bus_if.done}, 32'd1);
    endtask

    task automatic do_add(input logic [3:0] v);
        bus_if.add_valid = 1'b1;
        bus_if.add_value = v;
        step();
        bus_if.add_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus_if.clear = 1'b1;
        step();
        bus_if.clear = 1'b0;
    endtask

    task automatic preload(input int target, input logic [15:0] bcd);
        int rem;
        int cyc;
        logic [3:0] v;
        pulse_clear();
        rem = target;
        while (rem > 0) begin
            v = (rem > 9) ? 4'd9 : 4'(rem);
            do_add(v);
            wait_done(cyc);
            rem -= int'(v);
        end
        check("preload", {16'b0, bus_if.score}, {16'b0, bcd});
    endtask

    initial begin
        int cyc;
        n_cmp = 0;
        n_bad = 0;
        resetN = 1'b0;
        bus_if.clear = 1'b0;
        bus_if.add_valid = 1'b0;
        bus_if.add_value = 4'd0;
        #12;
        check("rst_score", {16'b0, bus_if.score}, 32'h0);
        check("rst_ready", {31'b0, bus_if.add_ready}, 32'd1);
        check("rst_flags", {29'b0, bus_if.busy, bus_if.done, bus_if.overflow}, 32'd0);
        resetN = 1'b1;
        step();

        // 0099 + 1: three-digit ripple
        preload(99, 16'h0099);
        do_add(4'd1);
        check("t2_e0_busy", {31'b0, bus_if.busy}, 32'd1);
        check("t2_e0_score", {16'b0, bus_if.score}, 32'h0099);
        check("t2_e0_ready", {31'b0, bus_if.add_ready}, 32'd0);
        step();
        check("t2_e1_score", {16'b0, bus_if.score}, 32'h0090);
        check("t2_e1_busy", {31'b0, bus_if.busy}, 32'd1);
        step();
        check("t2_e2_score", {16'b0, bus_if.score}, 32'h0000);
        check("t2_e2_done", {31'b0, bus_if.done}, 32'd0);
        step();
        check("t2_e3_score", {16'b0, bus_if.score}, 32'h0100);
        check("t2_e3_st", {29'b0, bus_if.busy, bus_if.done, bus_if.add_ready}, 32'b011);
        step();
        check("t2_e4_done", {31'b0, bus_if.done}, 32'd0);

        // 0012 + 15 clamps to 9: one carry, two digits processed
        preload(12, 16'h0012);
        do_add(4'd15);
        wait_done(cyc);
        check("t3_cycles", 32'(cyc), 32'd2);
        check("t3_score", {16'b0, bus_if.score}, 32'h0021);
        check("t3_ovf", {31'b0, bus_if.overflow}, 32'd0);

        // async reset mid-ADD
        preload(999, 16'h0999);
        do_add(4'd1);
        step();
        check("t1_mid", {16'b0, bus_if.score}, 32'h0990);
        resetN = 1'b0;
        #1;
        check("t1_score", {16'b0, bus_if.score}, 32'h0);
        check("t1_ready", {31'b0, bus_if.add_ready}, 32'd1);
        check("t1_flags", {29'b0, bus_if.busy, bus_if.done, bus_if.overflow}, 32'd0);
        #2;
        resetN = 1'b1;
        step();

        // 9995 + 7 saturates, further add re-saturates
        preload(9995, 16'h9995);
        do_add(4'd7);
        wait_done(cyc);
        check("t4_cycles", 32'(cyc), 32'd4);
        check("t4_score", {16'b0, bus_if.score}, 32'h9999);
        check("t4_ovf", {31'b0, bus_if.overflow}, 32'd1);
        do_add(4'd1);
        wait_done(cyc);
        check("t4b_cycles", 32'(cyc), 32'd4);
        check("t4b_score", {16'b0, bus_if.score}, 32'h9999);
        check("t4b_ovf", {31'b0, bus_if.overflow}, 32'd1);

        // clear during ADD aborts the add and drops overflow
        do_add(4'd1);
        step();
        check("t6b_mid", {16'b0, bus_if.score}, 32'h9990);
        bus_if.clear = 1'b1;
        #1;
        check("t6b_ready", {31'b0, bus_if.add_ready}, 32'd0);
        step();
        bus_if.clear = 1'b0;
        check("t6b_score", {16'b0, bus_if.score}, 32'h0);
        check("t6b_flags", {29'b0, bus_if.busy, bus_if.done, bus_if.overflow}, 32'd0);
        step();
        check("t6b_nodone", {31'b0, bus_if.done}, 32'd0);

        // add_valid held through ADD: second request waits for done
        bus_if.add_valid = 1'b1;
        bus_if.add_value = 4'd5;
        step();
        check("t5_e0_busy", {31'b0, bus_if.busy}, 32'd1);
        step();
        check("t5_e1_done", {31'b0, bus_if.done}, 32'd1);
        check("t5_e1_score", {16'b0, bus_if.score}, 32'h0005);
        step();
        bus_if.add_valid = 1'b0;
        check("t5_e2_st", {30'b0, bus_if.busy, bus_if.done}, 32'b10);
        wait_done(cyc);
        check("t5_score", {16'b0, bus_if.score}, 32'h0010);

        // clear together with add_valid: request dropped
        bus_if.clear = 1'b1;
        bus_if.add_valid = 1'b1;
        bus_if.add_value = 4'd3;
        #1;
        check("t6a_ready", {31'b0, bus_if.add_ready}, 32'd0);
        step();
        bus_if.clear = 1'b0;
        bus_if.add_valid = 1'b0;
        check("t6a_score", {16'b0, bus_if.score}, 32'h0);
        check("t6a_flags", {29'b0, bus_if.busy, bus_if.done, bus_if.overflow}, 32'd0);
        step();
        check("t6a_idle", {16'b0, bus_if.score, 15'b0, bus_if.busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
